// File: rtl/fps_pkg.sv
// Shared FP32 field constants, class-flag indices, issue FSM state encoding and
// the IEEE-754 class decoder used when a result is captured.
package fps_pkg;

  localparam int         SIGN    = 31;
  localparam int         EXP_MSB = 30;
  localparam int         EXP_LSB = 23;
  localparam int         FRAC_W  = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  localparam int FLG_NAN  = 3;
  localparam int FLG_INF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_DEN  = 0;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_WAIT = 2'd1,
    FSM_HOLD = 2'd2
  } fsm_state_e;

  // Exactly one of the four classes can match, so at most one bit is set.
  function automatic logic [3:0] fp32_classify(input logic [31:0] c);
    logic [7:0]        e;
    logic [FRAC_W-1:0] f;
    logic [3:0]        fl;
    e  = c[EXP_MSB:EXP_LSB];
    f  = c[FRAC_W-1:0];
    fl = '0;
    fl[FLG_NAN]  = (e == EXP_MAX) && (f != '0);
    fl[FLG_INF]  = (e == EXP_MAX) && (f == '0);
    fl[FLG_ZERO] = (e == 8'h00)   && (f == '0);
    fl[FLG_DEN]  = (e == 8'h00)   && (f != '0);
    return fl;
  endfunction

endpackage

// File: rtl/fps_issue_seq_if.sv
// Operand-in and result-out streams of the fps issue stage.
interface fps_issue_seq_if;
  // Both streams: a transfer happens on a rising edge where valid && ready;
  // the source holds valid and payload stable until that edge, and ready never
  // depends combinationally on valid.
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_c, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_c, out_flags
  );
endinterface

// File: rtl/fps_op_fifo.sv
// Synchronous operand FIFO; pointers carry one extra wrap bit to tell full from empty.
module fps_op_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [64:0] din,
  input  logic        pop,
  output logic [64:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [64:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fps_issue_seq.sv
// Issue stage for the combinational fps subtractor: queue operand pairs, hold each
// pair on fps for SETTLE cycles, capture and classify the result, hand it downstream.
module fps_issue_seq
  import fps_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  fps_issue_seq_if.slave  bus,
  output logic [31:0]     fps_a,
  output logic [31:0]     fps_b,
  input  logic [31:0]     fps_c,
  output logic [3:0]      sticky_flags,
  input  logic            clr_sticky,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] IDLE = FSM_IDLE;
  localparam logic [1:0] WAIT = FSM_WAIT;
  localparam logic [1:0] HOLD = FSM_HOLD;
  localparam int         CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          load;
  logic          capture;
  logic [64:0]   head;
  logic [31:0]   head_a;
  logic [31:0]   head_b;
  logic          head_op;
  logic [3:0]    flags_new;
  logic          out_valid_q;
  logic [31:0]   out_c_q;
  logic [3:0]    out_flags_q;
  logic [3:0]    sticky_q;

  assign push    = bus.in_valid && bus.in_ready;
  assign head_a  = head[31:0];
  assign head_b  = head[63:32];
  assign head_op = head[64];

  // A pop always coincides with loading fps, either from IDLE or on the
  // downstream handshake out of HOLD.
  assign load      = !empty && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
  assign capture   = (state == WAIT) && (cnt == '0);
  assign flags_new = fp32_classify(fps_c);

  fps_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.in_op, bus.in_b, bus.in_a}),
    .pop   (load),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      fps_a       <= '0;
      fps_b       <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_flags_q <= '0;
      sticky_q    <= '0;
    end else begin
      // fps only subtracts, so an add is issued as A - (-B).
      if (load) begin
        fps_a <= head_a;
        fps_b <= head_op ? {~head_b[SIGN], head_b[SIGN-1:0]} : head_b;
        cnt   <= CW'(SETTLE - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (capture) begin
        out_c_q     <= fps_c;
        out_flags_q <= flags_new;
        sticky_q    <= (clr_sticky ? 4'b0000 : sticky_q) | flags_new;
      end else if (clr_sticky) begin
        sticky_q <= '0;
      end

      case (state)
        IDLE: if (load) state <= WAIT;
        WAIT: begin
          if (capture) begin
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= load ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_c     = out_c_q;
  assign bus.out_flags = out_flags_q;
  assign sticky_flags  = sticky_q;
  assign dbg_state     = state;

endmodule
